// File: rtl/draw_player_anim_if.sv
// VGA pixel stream bundle: raster position, sync/blank strobes and 12-bit colour.
interface vga_if;
  logic [11:0] vcount;
  logic [11:0] hcount;
  logic        vsync;
  logic        hsync;
  logic        vblnk;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
  modport out (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
endinterface

// File: rtl/draw_player_anim.sv
// Animated player sprite overlay. Position, mode and enable are captured once
// per frame on the rising edge of vblnk; the pixel path is a fixed three-stage
// pipeline (offset -> region decode -> colour select) and every VGA field is
// delayed by the same three cycles.
module draw_player_anim #(
  parameter int          W        = 40,
  parameter int          EAR_H    = 10,
  parameter int          BODY_H   = 60,
  parameter int          LEG_H    = 20,
  parameter int          EYE_R2   = 30,
  parameter int          ANIM_DIV = 8,
  parameter logic [11:0] BODY_RGB = 12'hF0F,
  parameter logic [11:0] EYE_RGB  = 12'h0FF
) (
  input  logic        clk,
  input  logic        rst,
  vga_if.in           vga_in,
  vga_if.out          vga_out,
  input  logic        en,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic [1:0]  mode
);

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_RIGHT = 2'd1,
    MODE_LEFT  = 2'd2
  } mode_e;

  typedef struct packed {
    logic [11:0] vcount;
    logic [11:0] hcount;
    logic        vsync;
    logic        hsync;
    logic        vblnk;
    logic        hblnk;
    logic [11:0] rgb;
  } vga_t;

  localparam int CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ANIM_DIV - 1);

  // Sprite geometry as 12-bit constants so all row/column compares match width.
  localparam logic [11:0] W_L    = 12'(W);
  localparam logic [11:0] W_M1   = 12'(W - 1);
  localparam logic [11:0] W_M10  = 12'(W - 10);
  localparam logic [11:0] W_M11  = 12'(W - 11);
  localparam logic [11:0] W_M15  = 12'(W - 15);
  localparam logic [11:0] W_M16  = 12'(W - 16);
  localparam logic [11:0] EAR_L  = 12'(EAR_H);
  localparam logic [11:0] BEND_L = 12'(EAR_H + BODY_H);
  localparam logic [11:0] HT_L   = 12'(EAR_H + BODY_H + LEG_H);
  localparam logic [11:0] EYEY_L = 12'(EAR_H + 20);
  localparam logic [13:0] EX1_14 = 14'd10;
  localparam logic [13:0] EX2_14 = 14'd27;
  localparam logic [13:0] EY_14  = 14'(EAR_H + 20);
  localparam logic [26:0] R2_L   = 27'(EYE_R2);

  // Magnitude of a 14-bit two's-complement offset; |d| stays below 8192.
  function automatic logic [12:0] abs13(input logic [13:0] v);
    logic [13:0] n;
    n = v[13] ? (~v + 14'd1) : v;
    return n[12:0];
  endfunction

  // ---------------- per-frame latches and walk animation ----------------
  logic             vblnk_prev_q;
  logic [11:0]      xpos_l_q, xpos_l_d;
  logic [11:0]      ypos_l_q, ypos_l_d;
  logic             en_l_q, en_l_d;
  mode_e            mode_l_q, mode_l_d;
  logic [CNT_W-1:0] anim_cnt_q, anim_cnt_d;
  logic             phase_q, phase_d;
  logic             frame_start;
  mode_e            mode_in;

  assign frame_start = vga_in.vblnk & ~vblnk_prev_q;
  assign mode_in = (mode == 2'd1) ? MODE_RIGHT :
                   (mode == 2'd2) ? MODE_LEFT  : MODE_IDLE;

  // Next-frame state: capture inputs and advance the walk cycle at frame start.
  always_comb begin
    xpos_l_d   = xpos_l_q;
    ypos_l_d   = ypos_l_q;
    en_l_d     = en_l_q;
    mode_l_d   = mode_l_q;
    anim_cnt_d = anim_cnt_q;
    phase_d    = phase_q;
    if (frame_start) begin
      xpos_l_d = xpos;
      ypos_l_d = ypos;
      en_l_d   = en;
      mode_l_d = mode_in;
      if (mode_in == MODE_IDLE) begin
        anim_cnt_d = '0;
        phase_d    = 1'b0;
      end else if (anim_cnt_q == CNT_MAX) begin
        anim_cnt_d = '0;
        phase_d    = ~phase_q;
      end else begin
        anim_cnt_d = anim_cnt_q + CNT_W'(1);
      end
    end
  end

  // Frame-level registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_prev_q <= 1'b0;
      xpos_l_q     <= '0;
      ypos_l_q     <= '0;
      en_l_q       <= 1'b0;
      mode_l_q     <= MODE_IDLE;
      anim_cnt_q   <= '0;
      phase_q      <= 1'b0;
    end else begin
      vblnk_prev_q <= vga_in.vblnk;
      xpos_l_q     <= xpos_l_d;
      ypos_l_q     <= ypos_l_d;
      en_l_q       <= en_l_d;
      mode_l_q     <= mode_l_d;
      anim_cnt_q   <= anim_cnt_d;
      phase_q      <= phase_d;
    end
  end

  // ---------------- stage 1: offsets from sprite origin ----------------
  vga_t               in_t;
  vga_t               s1_t_q;
  logic signed [12:0] s1_dx_q, s1_dy_q;
  logic               s1_en_q;
  mode_e              s1_mode_q;
  logic               s1_phase_q;

  assign in_t = '{vcount: vga_in.vcount, hcount: vga_in.hcount,
                  vsync: vga_in.vsync, hsync: vga_in.hsync,
                  vblnk: vga_in.vblnk, hblnk: vga_in.hblnk, rgb: vga_in.rgb};

  // Stage 1: 13-bit signed offsets; frame settings travel with the pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_t_q     <= '0;
      s1_dx_q    <= '0;
      s1_dy_q    <= '0;
      s1_en_q    <= 1'b0;
      s1_mode_q  <= MODE_IDLE;
      s1_phase_q <= 1'b0;
    end else begin
      s1_t_q     <= in_t;
      s1_dx_q    <= $signed({1'b0, vga_in.hcount}) - $signed({1'b0, xpos_l_q});
      s1_dy_q    <= $signed({1'b0, vga_in.vcount}) - $signed({1'b0, ypos_l_q});
      s1_en_q    <= en_l_q;
      s1_mode_q  <= mode_l_q;
      s1_phase_q <= phase_q;
    end
  end

  // ---------------- stage 2: region decode and eye distances ----------------
  logic [11:0] ux, uy, dm;
  logic        in_box;
  logic        ear_top, ear_row, body_row, leg_row, out10, out15, idle_body;
  logic        side_eye, leg_p0, leg_p1, side_body;
  logic [13:0] ex1, ex2, ey;
  logic [12:0] mx1, mx2, my;
  logic [25:0] sqx1, sqx2, sqy;

  // Low bits are the true column/row only when the offset is non-negative,
  // which in_box guarantees before any flag is used.
  assign ux     = s1_dx_q[11:0];
  assign uy     = s1_dy_q[11:0];
  assign in_box = ~s1_dx_q[12] & ~s1_dy_q[12] & (ux < W_L) & (uy < HT_L);

  assign ear_top   = uy < 12'd5;
  assign ear_row   = uy < EAR_L;
  assign body_row  = ~ear_row & (uy < BEND_L);
  assign leg_row   = ~(uy < BEND_L);
  assign out10     = (ux < 12'd10) | (ux >= W_M10);
  assign out15     = (ux < 12'd15) | (ux >= W_M15);
  assign idle_body = (ear_top & out10) | (ear_row & ~ear_top & out15) |
                     body_row | (leg_row & out15);

  // The left view is the right view read with a mirrored column.
  assign dm        = (s1_mode_q == MODE_LEFT) ? (W_M1 - ux) : ux;
  assign side_eye  = (dm >= W_M15) & (dm <= W_M11) &
                     (uy >= EYEY_L) & (uy <= EYEY_L + 12'd19);
  assign leg_p0    = (dm >= 12'd5) & (dm <= 12'd19);
  assign leg_p1    = (dm <= 12'd9) | ((dm >= 12'd15) & (dm <= 12'd24));
  assign side_body = ((dm <= W_M16) & ~leg_row) |
                     (leg_row & (s1_phase_q ? leg_p1 : leg_p0));

  assign ex1  = {s1_dx_q[12], s1_dx_q} - EX1_14;
  assign ex2  = {s1_dx_q[12], s1_dx_q} - EX2_14;
  assign ey   = {s1_dy_q[12], s1_dy_q} - EY_14;
  assign mx1  = abs13(ex1);
  assign mx2  = abs13(ex2);
  assign my   = abs13(ey);
  assign sqx1 = {13'd0, mx1} * {13'd0, mx1};
  assign sqx2 = {13'd0, mx2} * {13'd0, mx2};
  assign sqy  = {13'd0, my} * {13'd0, my};

  vga_t        s2_t_q;
  logic        s2_draw_q, s2_idle_q, s2_body_q, s2_side_eye_q;
  logic [25:0] s2_sqx1_q, s2_sqx2_q, s2_sqy_q;

  // Stage 2: register the decoded flags and squared eye distances.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_t_q        <= '0;
      s2_draw_q     <= 1'b0;
      s2_idle_q     <= 1'b0;
      s2_body_q     <= 1'b0;
      s2_side_eye_q <= 1'b0;
      s2_sqx1_q     <= '0;
      s2_sqx2_q     <= '0;
      s2_sqy_q      <= '0;
    end else begin
      s2_t_q        <= s1_t_q;
      s2_draw_q     <= s1_en_q & in_box;
      s2_idle_q     <= (s1_mode_q == MODE_IDLE);
      s2_body_q     <= (s1_mode_q == MODE_IDLE) ? idle_body : side_body;
      s2_side_eye_q <= side_eye;
      s2_sqx1_q     <= sqx1;
      s2_sqx2_q     <= sqx2;
      s2_sqy_q      <= sqy;
    end
  end

  // ---------------- stage 3: colour select ----------------
  logic idle_eye;
  vga_t s3_d, s3_q;

  assign idle_eye = (({1'b0, s2_sqx1_q} + {1'b0, s2_sqy_q}) <= R2_L) |
                    (({1'b0, s2_sqx2_q} + {1'b0, s2_sqy_q}) <= R2_L);

  // Eye beats body; anything not covered keeps the upstream colour.
  always_comb begin
    s3_d = s2_t_q;
    if (s2_draw_q) begin
      if (s2_idle_q ? idle_eye : s2_side_eye_q) s3_d.rgb = EYE_RGB;
      else if (s2_body_q)                       s3_d.rgb = BODY_RGB;
    end
  end

  // Stage 3: output register.
  always_ff @(posedge clk) begin
    if (rst) s3_q <= '0;
    else     s3_q <= s3_d;
  end

  assign vga_out.vcount = s3_q.vcount;
  assign vga_out.hcount = s3_q.hcount;
  assign vga_out.vsync  = s3_q.vsync;
  assign vga_out.hsync  = s3_q.hsync;
  assign vga_out.vblnk  = s3_q.vblnk;
  assign vga_out.hblnk  = s3_q.hblnk;
  assign vga_out.rgb    = s3_q.rgb;

endmodule

// File: tb/tb_draw_player_anim.sv
// Bench for draw_player_anim: drives pixels directly (no raster generator),
// predicts each output from a behavioural sprite model or a fixed colour, and
// compares three cycles later through an expected-value queue.
module tb_draw_player_anim;

  localparam int W = 40, EAR_H = 10, BODY_H = 60, LEG_H = 20, EYE_R2 = 30;
  localparam int ANIM_DIV = 2;
  localparam logic [11:0] BODY_RGB = 12'hF0F, EYE_RGB = 12'h0FF;
  localparam int K_MODEL = 0, K_EYE = 1, K_BODY = 2, K_BG = 3;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [11:0] xpos = '0, ypos = '0;
  logic [1:0]  mode = '0;

  vga_if vin();
  vga_if vout();

  draw_player_anim #(
    .W(W), .EAR_H(EAR_H), .BODY_H(BODY_H), .LEG_H(LEG_H), .EYE_R2(EYE_R2),
    .ANIM_DIV(ANIM_DIV), .BODY_RGB(BODY_RGB), .EYE_RGB(EYE_RGB)
  ) dut (
    .clk(clk), .rst(rst), .vga_in(vin), .vga_out(vout),
    .en(en), .xpos(xpos), .ypos(ypos), .mode(mode)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [39:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  string       tag_s = "init";

  int xl_m = 0, yl_m = 0, md_m = 0, cnt_m = 0;
  bit en_m = 1'b0, ph_m = 1'b0, vbp_m = 1'b0;

  task automatic check_eq(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%h exp=%h (vc,hc,vs,hs,vb,hb,rgb)", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] obs_out();
    return {vout.vcount, vout.hcount, vout.vsync, vout.hsync, vout.vblnk, vout.hblnk, vout.rgb};
  endfunction

  // Behavioural sprite picture straight from the drawing rules.
  function automatic logic [11:0] model_rgb(input int h, input int v, input logic [11:0] bg);
    int dx, dy, dm, ht;
    dx = h - xl_m;
    dy = v - yl_m;
    ht = EAR_H + BODY_H + LEG_H;
    if (!en_m || dx < 0 || dy < 0 || dx >= W || dy >= ht) return bg;
    if (md_m == 1 || md_m == 2) begin
      dm = (md_m == 2) ? (W - 1 - dx) : dx;
      if (dm >= W - 15 && dm <= W - 11 && dy >= EAR_H + 20 && dy <= EAR_H + 39) return EYE_RGB;
      if (dm <= W - 16 && dy < EAR_H + BODY_H) return BODY_RGB;
      if (dy >= EAR_H + BODY_H) begin
        if (!ph_m && dm >= 5 && dm <= 19) return BODY_RGB;
        if (ph_m && (dm <= 9 || (dm >= 15 && dm <= 24))) return BODY_RGB;
      end
      return bg;
    end
    if ((dx - 10) * (dx - 10) + (dy - EAR_H - 20) * (dy - EAR_H - 20) <= EYE_R2) return EYE_RGB;
    if ((dx - 27) * (dx - 27) + (dy - EAR_H - 20) * (dy - EAR_H - 20) <= EYE_R2) return EYE_RGB;
    if (dy < 5)              return (dx < 10 || dx >= 30) ? BODY_RGB : bg;
    if (dy < EAR_H)          return (dx < 15 || dx >= 25) ? BODY_RGB : bg;
    if (dy < EAR_H + BODY_H) return BODY_RGB;
    return (dx < 15 || dx >= 25) ? BODY_RGB : bg;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_px(input int h, input int v, input bit vb, input int kind);
    logic [11:0] bg, r;
    bit vs, hs, hb;
    bg = {4'h1, 8'($urandom)};
    vs = 1'($urandom);
    hs = 1'($urandom);
    hb = 1'($urandom);
    vin.hcount = 12'(h);
    vin.vcount = 12'(v);
    vin.vsync  = vs;
    vin.hsync  = hs;
    vin.vblnk  = vb;
    vin.hblnk  = hb;
    vin.rgb    = bg;
    case (kind)
      K_EYE:   r = EYE_RGB;
      K_BODY:  r = BODY_RGB;
      K_BG:    r = bg;
      default: r = model_rgb(h, v, bg);
    endcase
    exp_q.push_back({12'(v), 12'(h), vs, hs, vb, hb, r});
    if (vb && !vbp_m) begin
      xl_m = int'(xpos);
      yl_m = int'(ypos);
      en_m = en;
      md_m = (mode == 2'd1 || mode == 2'd2) ? int'(mode) : 0;
      if (md_m == 0) begin
        cnt_m = 0;
        ph_m  = 1'b0;
      end else if (cnt_m == ANIM_DIV - 1) begin
        cnt_m = 0;
        ph_m  = ~ph_m;
      end else begin
        cnt_m++;
      end
    end
    vbp_m = vb;
  endtask

  task automatic sample_out();
    logic [39:0] e;
    if (exp_q.size() >= 3) begin
      e = exp_q.pop_front();
      check_eq(tag_s, obs_out(), e);
    end
  endtask

  task automatic step(input int h, input int v, input bit vb, input int kind);
    @(negedge clk);
    sample_out();
    drive_px(h, v, vb, kind);
  endtask

  task automatic new_frame();
    step(0, 600, 1'b1, K_MODEL);
    step(0, 601, 1'b1, K_MODEL);
    step(0, 0, 1'b0, K_MODEL);
  endtask

  task automatic do_reset();
    @(negedge clk);
    sample_out();
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_eq("rst_edge1", obs_out(), 40'd0);
    @(negedge clk);
    check_eq("rst_edge2", obs_out(), 40'd0);
    rst   = 1'b0;
    xl_m  = 0; yl_m = 0; md_m = 0; cnt_m = 0;
    en_m  = 1'b0; ph_m = 1'b0; vbp_m = 1'b0;
    exp_q.push_back(40'd0);
    exp_q.push_back(40'd0);
    drive_px(int'($urandom_range(0, 1000)), int'($urandom_range(0, 700)), 1'b0, K_MODEL);
  endtask

  task automatic drain();
    logic [39:0] e;
    repeat (3) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq(tag_s, obs_out(), e);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vin.hcount = '0; vin.vcount = '0; vin.vsync = 1'b0; vin.hsync = 1'b0;
    vin.vblnk = 1'b0; vin.hblnk = 1'b0; vin.rgb = '0;

    tag_s = "reset";
    do_reset();
    tag_s = "post_reset_pass";
    repeat (10) step(int'($urandom_range(0, 800)), int'($urandom_range(0, 600)), 1'b0, K_MODEL);

    // IDLE front view
    en = 1'b1; xpos = 12'd100; ypos = 12'd400; mode = 2'd0;
    tag_s = "idle_frame"; new_frame();
    tag_s = "idle_eye";       step(110, 430, 1'b0, K_EYE);
    tag_s = "idle_body";      step(120, 450, 1'b0, K_BODY);
    tag_s = "idle_leg_gap";   step(120, 475, 1'b0, K_BG);
    tag_s = "idle_left_edge"; step(99, 450, 1'b0, K_BG);
    tag_s = "idle_rand";
    repeat (200) step(95 + int'($urandom_range(0, 50)), 395 + int'($urandom_range(0, 100)), 1'b0, K_MODEL);

    // Reset in the middle of a line, then re-latch on the next frame
    tag_s = "mid_reset"; do_reset();
    tag_s = "after_reset_pass"; step(110, 430, 1'b0, K_BG);
    tag_s = "relatch_frame"; new_frame();
    tag_s = "relatch_eye"; step(110, 430, 1'b0, K_EYE);

    // Latching: position change mid-frame waits for the next frame
    tag_s = "latch_frame"; new_frame();
    xpos = 12'd300;
    tag_s = "latch_old_pos";  step(110, 430, 1'b0, K_EYE);
    tag_s = "latch_not_yet";  step(310, 430, 1'b0, K_BG);
    tag_s = "latch_frame2"; new_frame();
    tag_s = "latch_new_pos";  step(310, 430, 1'b0, K_EYE);
    tag_s = "latch_old_gone"; step(110, 430, 1'b0, K_BG);

    // Walk animation, two frames per phase
    xpos = 12'd100; mode = 2'd0;
    tag_s = "walk_idle0"; new_frame();
    mode = 2'd1;
    tag_s = "walk_f1"; new_frame(); tag_s = "walk_f1_ph0"; step(102, 475, 1'b0, K_BG);
    tag_s = "walk_f2"; new_frame(); tag_s = "walk_f2_ph1"; step(102, 475, 1'b0, K_BODY);
    tag_s = "walk_f3"; new_frame(); tag_s = "walk_f3_ph1"; step(102, 475, 1'b0, K_BODY);
    tag_s = "walk_f4"; new_frame(); tag_s = "walk_f4_ph0"; step(102, 475, 1'b0, K_BG);
    tag_s = "walk_rand";
    repeat (80) step(98 + int'($urandom_range(0, 44)), 398 + int'($urandom_range(0, 94)), 1'b0, K_MODEL);
    mode = 2'd0;
    tag_s = "walk_idle"; new_frame(); tag_s = "walk_idle_leg"; step(102, 475, 1'b0, K_BODY);
    mode = 2'd1;
    tag_s = "walk_restart"; new_frame(); tag_s = "walk_restart_ph0"; step(102, 475, 1'b0, K_BG);

    // LEFT mirror at the screen edge
    mode = 2'd2; xpos = 12'd0;
    tag_s = "left_frame"; new_frame();
    tag_s = "left_eye_lo";   step(10, 430, 1'b0, K_EYE);
    tag_s = "left_eye_hi";   step(14, 449, 1'b0, K_EYE);
    tag_s = "left_body_lo";  step(15, 420, 1'b0, K_BODY);
    tag_s = "left_body_hi";  step(39, 420, 1'b0, K_BODY);
    tag_s = "left_dx0";      step(0, 420, 1'b0, K_BG);
    tag_s = "left_dx9";      step(9, 430, 1'b0, K_BG);
    tag_s = "left_rand";
    repeat (100) step(int'($urandom_range(0, 45)), 398 + int'($urandom_range(0, 94)), 1'b0, K_MODEL);

    // Right-edge position: no wrap into the left columns
    mode = 2'd0; xpos = 12'd4090;
    tag_s = "edge_frame"; new_frame();
    tag_s = "edge_nowrap";
    for (int h = 0; h <= 50; h++) step(h, 400 + int'($urandom_range(0, 89)), 1'b0, K_BG);
    tag_s = "edge_eye_tail"; step(4095, 430, 1'b0, K_EYE);

    // Disabled: straight pass-through
    en = 1'b0; xpos = 12'd100;
    tag_s = "dis_frame"; new_frame();
    tag_s = "dis_eye_pos";  step(110, 430, 1'b0, K_BG);
    tag_s = "dis_body_pos"; step(120, 450, 1'b0, K_BG);
    tag_s = "dis_rand";
    repeat (40) step(95 + int'($urandom_range(0, 50)), 395 + int'($urandom_range(0, 100)), 1'b0, K_MODEL);

    // Random frames: any mode (incl. 3), enable, position
    tag_s = "rand_frames";
    repeat (8) begin
      en   = ($urandom_range(0, 3) != 0);
      mode = 2'($urandom);
      xpos = 12'($urandom_range(0, 4095));
      ypos = 12'($urandom_range(0, 4095));
      new_frame();
      repeat (150)
        step((int'(xpos) + int'($urandom_range(0, 60)) - 10) & 4095,
             (int'(ypos) + int'($urandom_range(0, 110)) - 10) & 4095, 1'b0, K_MODEL);
    end

    drain();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
